// File: rtl/ram_responder_if.sv
// ram_responder_if: line-fill / write-back bus between the direct cache and its backing store.
//   ram_addr     word address, meaningful only while a strobe is high
//   ram_read     read strobe, one beat per cycle
//   ram_write    write strobe, one beat per cycle
//   ram_data_in  write data from the cache
//   ram_data_out read data returned to the cache
// Modports: master = cache side, slave = store side.
interface ram_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_read;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport master (
        output ram_addr, ram_read, ram_write, ram_data_in,
        input  ram_data_out
    );

    modport slave (
        input  ram_addr, ram_read, ram_write, ram_data_in,
        output ram_data_out
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: backing store for the direct cache's line-fill / write-back port.
// Serves zero-wait-state reads and single-cycle writes, tracks WORDS-beat line bursts,
// raises a sticky flag on protocol violations and counts completed bursts.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   bus (slave)       ram_addr / ram_read / ram_write / ram_data_in / ram_data_out
//   dbg_addr/we/wdata side-band preload port, honoured only while the bus is idle
//   dbg_rdata         mem[dbg_addr], combinational
//   burst_done        one-cycle pulse the cycle after the final beat of a burst
//   proto_err         sticky protocol-violation flag, cleared only by rst
//   rd_bursts         completed read bursts, saturating
//   wr_bursts         completed write bursts, saturating
module ram_responder #(
    parameter int WORDS      = 8,
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 9,
    parameter int OFFSET     = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_responder_if.slave        bus,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic                  dbg_we,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  burst_done,
    output logic                  proto_err,
    output logic [15:0]           rd_bursts,
    output logic [15:0]           wr_bursts
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [OFFSET:0] LAST_BEAT = (OFFSET+1)'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    state_t                       state, state_nxt;
    logic [OFFSET:0]              beat_cnt, beat_cnt_nxt;
    logic [ADDR_WIDTH-OFFSET-1:0] base, base_nxt;
    logic [ADDR_WIDTH-1:0]        exp_addr;

    logic rd_en, wr_en, both_en, dbg_commit;
    logic err_p0, done_rd_p0, done_wr_p0;
    logic proto_err_p1, done_p1;
    logic [15:0] rd_cnt, wr_cnt;

    // Stage p0: decode strobes and burst tracking (combinational)
    assign rd_en    = bus.ram_read & ~bus.ram_write;
    assign wr_en    = bus.ram_write & ~bus.ram_read;
    assign both_en  = bus.ram_read & bus.ram_write;
    assign exp_addr = {base, beat_cnt[OFFSET-1:0]};

    // Strobes idle and tracker idle, so a debug write can never collide with a bus write.
    assign dbg_commit = dbg_we & (state == IDLE) & ~bus.ram_read & ~bus.ram_write;

    assign bus.ram_data_out = rd_en ? mem[bus.ram_addr] : '0;
    assign dbg_rdata        = mem[dbg_addr];

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        base_nxt     = base;
        err_p0       = 1'b0;
        done_rd_p0   = 1'b0;
        done_wr_p0   = 1'b0;
        case (state)
            IDLE: begin
                if (both_en) begin
                    err_p0 = 1'b1;
                end else if (rd_en || wr_en) begin
                    base_nxt     = bus.ram_addr[ADDR_WIDTH-1:OFFSET];
                    beat_cnt_nxt = (OFFSET+1)'(1);
                    state_nxt    = rd_en ? RD_BURST : WR_BURST;
                    // Misaligned start is flagged but the beat is still served.
                    if (bus.ram_addr[OFFSET-1:0] != '0) begin
                        err_p0 = 1'b1;
                    end
                end
            end
            RD_BURST, WR_BURST: begin
                if ((state == RD_BURST && rd_en) || (state == WR_BURST && wr_en)) begin
                    if (bus.ram_addr != exp_addr) begin
                        err_p0 = 1'b1;
                    end
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                        done_rd_p0   = (state == RD_BURST);
                        done_wr_p0   = (state == WR_BURST);
                    end else begin
                        beat_cnt_nxt = beat_cnt + (OFFSET+1)'(1);
                    end
                end else begin
                    // Gap, opposite strobe or both strobes: abandon the burst.
                    // An opposite-strobe beat is still served by the datapath
                    // but does not open a new burst.
                    err_p0       = 1'b1;
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    // Stage p1: control registers, flags and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            proto_err_p1 <= 1'b0;
            done_p1      <= 1'b0;
            rd_cnt       <= 16'd0;
            wr_cnt       <= 16'd0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            done_p1  <= done_rd_p0 | done_wr_p0;
            if (err_p0) begin
                proto_err_p1 <= 1'b1;
            end
            if (done_rd_p0) begin
                rd_cnt <= sat_inc(rd_cnt);
            end
            if (done_wr_p0) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        base <= base_nxt;
    end

    // Storage: reset reloads the identity pattern; an in-flight write is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
        end else if (wr_en) begin
            mem[bus.ram_addr] <= bus.ram_data_in;
        end else if (dbg_commit) begin
            mem[dbg_addr] <= dbg_wdata;
        end
    end

    assign burst_done = done_p1;
    assign proto_err  = proto_err_p1;
    assign rd_bursts  = rd_cnt;
    assign wr_bursts  = wr_cnt;
endmodule
